pipelined_cla_add_sub: RTL and testbench



---
 rtl/pipelined_cla_add_sub.sv | 130 +++++++++++++
 tb/tb_pipelined_cla_add_sub.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_add_sub.sv
// Pipelined adder/subtractor: one GROUP-bit carry-lookahead group per stage.
// Each beat carries its group carry, partial result and unconsumed operand bits down the pipe.
module pipelined_cla_add_sub #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             v_o,
  output logic             z_o
);

  localparam int NSTG = WIDTH / GROUP;

  if (GROUP < 1 || GROUP > WIDTH || (WIDTH % GROUP) != 0) begin : g_param_check
    $error("pipelined_cla_add_sub: WIDTH must be a non-zero multiple of GROUP");
  end

  logic [WIDTH-1:0] a_q   [NSTG];
  logic [WIDTH-1:0] b_q   [NSTG];
  logic [WIDTH-1:0] s_q   [NSTG];
  logic [NSTG-1:0]  c_q;
  logic [NSTG-1:0]  vld_q;
  logic             v_q;
  logic             z_q;

  logic [WIDTH-1:0] a_src [NSTG];
  logic [WIDTH-1:0] b_src [NSTG];
  logic [WIDTH-1:0] s_src [NSTG];
  logic [NSTG-1:0]  c_src;
  logic [NSTG-1:0]  vld_src;

  logic [GROUP+1:0] grp   [NSTG];
  logic [WIDTH-1:0] s_nxt [NSTG];
  logic [NSTG-1:0]  c_nxt;
  logic             v_nxt;
  logic             z_nxt;
  logic             en;

  // Returns {carry into group MSB, group carry-out, group sum}.
  function automatic logic [GROUP+1:0] cla_group(
    input logic [GROUP-1:0] a,
    input logic [GROUP-1:0] b,
    input logic             cin
  );
    logic [GROUP:0]   c;
    logic [GROUP-1:0] s;
    c[0] = cin;
    for (int j = 0; j < GROUP; j++) begin
      c[j+1] = (a[j] & b[j]) | ((a[j] | b[j]) & c[j]);
      s[j]   = a[j] ^ b[j] ^ c[j];
    end
    return {c[GROUP-1], c[GROUP], s};
  endfunction

  assign en         = ~vld_q[NSTG-1] | out_ready_i;
  assign in_ready_o = en;

  // Stage 0 sees the conditioned inputs; subtraction becomes A + ~B + ~c_i.
  always_comb begin
    c_src      = '0;
    vld_src    = '0;
    a_src[0]   = a_i;
    b_src[0]   = sub_i ? ~b_i : b_i;
    s_src[0]   = '0;
    c_src[0]   = c_i ^ sub_i;
    vld_src[0] = in_valid_i;
    for (int k = 1; k < NSTG; k++) begin
      a_src[k]   = a_q[k-1];
      b_src[k]   = b_q[k-1];
      s_src[k]   = s_q[k-1];
      c_src[k]   = c_q[k-1];
      vld_src[k] = vld_q[k-1];
    end
  end

  always_comb begin
    c_nxt = '0;
    for (int k = 0; k < NSTG; k++) begin
      grp[k]   = cla_group(a_src[k][k*GROUP +: GROUP], b_src[k][k*GROUP +: GROUP], c_src[k]);
      s_nxt[k] = s_src[k];
      s_nxt[k][k*GROUP +: GROUP] = grp[k][GROUP-1:0];
      c_nxt[k] = grp[k][GROUP];
    end
    v_nxt = grp[NSTG-1][GROUP+1] ^ grp[NSTG-1][GROUP];
    z_nxt = ~|s_nxt[NSTG-1];
  end

  // A single advance enable moves the whole pipe, bubbles included.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      c_q   <= '0;
      v_q   <= 1'b0;
      z_q   <= 1'b0;
      for (int k = 0; k < NSTG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (en) begin
      vld_q <= vld_src;
      c_q   <= c_nxt;
      v_q   <= v_nxt;
      z_q   <= z_nxt;
      for (int k = 0; k < NSTG; k++) begin
        a_q[k] <= a_src[k];
        b_q[k] <= b_src[k];
        s_q[k] <= s_nxt[k];
      end
    end
  end

  assign out_valid_o = vld_q[NSTG-1];
  assign s_o         = s_q[NSTG-1];
  assign c_o         = c_q[NSTG-1];
  assign v_o         = v_q;
  assign z_o         = z_q;

endmodule

// File: tb/tb_pipelined_cla_add_sub.sv
// Testbench for pipelined_cla_add_sub: directed vectors, streaming with stalls,
// reset flush and randomized traffic on three width/group configurations.
module tb_pipelined_cla_add_sub;

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        v;
    logic        z;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic        c16, sub16, co16, v16, z16;
  logic [15:0] a16, b16, s16;

  logic        in_valid_x, out_ready_x, c_x, sub_x;
  logic [31:0] a_x, b_x;
  logic        in_ready32, out_valid32, co32, v32, z32;
  logic [31:0] s32;
  logic        in_ready8, out_valid8, co8, v8, z8;
  logic [7:0]  s8;

  int errors = 0;
  int checks = 0;

  pipelined_cla_add_sub #(.WIDTH(16), .GROUP(4)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid16), .in_ready_o(in_ready16),
    .a_i(a16), .b_i(b16), .c_i(c16), .sub_i(sub16),
    .out_valid_o(out_valid16), .out_ready_i(out_ready16),
    .s_o(s16), .c_o(co16), .v_o(v16), .z_o(z16)
  );

  pipelined_cla_add_sub #(.WIDTH(32), .GROUP(8)) dut32 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_x), .in_ready_o(in_ready32),
    .a_i(a_x), .b_i(b_x), .c_i(c_x), .sub_i(sub_x),
    .out_valid_o(out_valid32), .out_ready_i(out_ready_x),
    .s_o(s32), .c_o(co32), .v_o(v32), .z_o(z32)
  );

  pipelined_cla_add_sub #(.WIDTH(8), .GROUP(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_x), .in_ready_o(in_ready8),
    .a_i(a_x[7:0]), .b_i(b_x[7:0]), .c_i(c_x), .sub_i(sub_x),
    .out_valid_o(out_valid8), .out_ready_i(out_ready_x),
    .s_o(s8), .c_o(co8), .v_o(v8), .z_o(z8)
  );

  // Integer reference: unsigned result for sum/carry, signed result for overflow.
  function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic c, input logic sub);
    longint lim, ua, ub, sa, sb, ci, r, sr;
    res_t   res;
    lim = longint'(1) << w;
    ua  = longint'(a) & (lim - 1);
    ub  = longint'(b) & (lim - 1);
    sa  = a[w-1] ? ua - lim : ua;
    sb  = b[w-1] ? ub - lim : ub;
    ci  = c ? longint'(1) : longint'(0);
    if (!sub) begin
      r      = ua + ub + ci;
      sr     = sa + sb + ci;
      res.co = (r >= lim);
    end else begin
      r      = ua - ub - ci;
      sr     = sa - sb - ci;
      res.co = (r >= 0);
    end
    res.s = 64'(r & (lim - 1));
    res.v = (sr < -(lim / 2)) || (sr > (lim / 2) - 1);
    res.z = (res.s == 64'd0);
    return res;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; c16 = 1'b0; sub16 = 1'b0;
    in_valid_x = 1'b0; out_ready_x = 1'b1; a_x = '0; b_x = '0; c_x = 1'b0; sub_x = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (out_valid16 !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid16); end
    checks++; if (s16 !== 16'h0) begin errors++; $display("[TB] FAIL reset_s: got %h want 0000", s16); end
    checks++; if (co16 !== 1'b0) begin errors++; $display("[TB] FAIL reset_c: got %b want 0", co16); end
    checks++; if (v16 !== 1'b0) begin errors++; $display("[TB] FAIL reset_v: got %b want 0", v16); end
    checks++; if (z16 !== 1'b0) begin errors++; $display("[TB] FAIL reset_z: got %b want 0", z16); end
    checks++; if (in_ready16 !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready16); end
    checks++; if (out_valid32 !== 1'b0 || out_valid8 !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out_valid_xcfg: got %b%b want 00", out_valid32, out_valid8);
    end
  endtask

  task automatic test_directed();
    logic [15:0] va [7] = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'h0005, 16'h8000, 16'h0010, 16'h0000};
    logic [15:0] vb [7] = '{16'h0001, 16'h0001, 16'h0FFF, 16'h0007, 16'h0001, 16'h0010, 16'h0000};
    logic        vc [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        vs [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    res_t e;
    int   lat;
    for (int i = 0; i < 7; i++) begin
      a16 = va[i]; b16 = vb[i]; c16 = vc[i]; sub16 = vs[i];
      in_valid16 = 1'b1; out_ready16 = 1'b1;
      e = model(16, {48'b0, va[i]}, {48'b0, vb[i]}, vc[i], vs[i]);
      #1;
      checks++; if (in_ready16 !== 1'b1) begin errors++; $display("[TB] FAIL directed_in_ready[%0d]: got %b want 1", i, in_ready16); end
      @(posedge clk); #1;
      in_valid16 = 1'b0; a16 = ~va[i]; b16 = ~vb[i]; c16 = ~vc[i]; sub16 = ~vs[i];
      lat = 1;
      while (out_valid16 !== 1'b1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++; if (lat != 4) begin errors++; $display("[TB] FAIL directed_latency[%0d]: got %0d want 4", i, lat); end
      checks++;
      if ({s16, co16, v16, z16} !== {e.s[15:0], e.co, e.v, e.z}) begin
        errors++;
        $display("[TB] FAIL directed_result[%0d]: got s=%h c=%b v=%b z=%b want s=%h c=%b v=%b z=%b",
                 i, s16, co16, v16, z16, e.s[15:0], e.co, e.v, e.z);
      end
      @(posedge clk); #1;
      checks++; if (out_valid16 !== 1'b0) begin errors++; $display("[TB] FAIL directed_single_beat[%0d]: got out_valid %b want 0", i, out_valid16); end
    end
  endtask

  task automatic test_back_to_back(input bit stall);
    res_t        e;
    int          sent = 0, got = 0, last = 0;
    bit          frozen = 1'b0;
    logic [15:0] held_s = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      in_valid16 = (sent < 8); a16 = 16'(sent); b16 = 16'h0F0F; c16 = 1'b0; sub16 = 1'b0;
      out_ready16 = !(stall && cyc >= 5 && cyc <= 7);
      #1;
      if (frozen) begin
        checks++;
        if (out_valid16 !== 1'b1 || s16 !== held_s) begin
          errors++; $display("[TB] FAIL stall_hold: got valid=%b s=%h want valid=1 s=%h", out_valid16, s16, held_s);
        end
      end
      frozen = 1'b0;
      if (out_valid16 && !out_ready16) begin
        checks++; if (in_ready16 !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready: got %b want 0", in_ready16); end
        held_s = s16;
        frozen = 1'b1;
      end
      if (out_valid16 && out_ready16) begin
        e = model(16, 64'(got), 64'h0F0F, 1'b0, 1'b0);
        checks++;
        if ({s16, co16, v16, z16} !== {e.s[15:0], e.co, e.v, e.z}) begin
          errors++;
          $display("[TB] FAIL stream_result[%0d]: got s=%h c=%b v=%b z=%b want s=%h c=%b v=%b z=%b",
                   got, s16, co16, v16, z16, e.s[15:0], e.co, e.v, e.z);
        end
        if (got > 0 && !stall) begin
          checks++; if (cyc != last + 1) begin errors++; $display("[TB] FAIL stream_gap[%0d]: got cycle %0d want %0d", got, cyc, last + 1); end
        end
        last = cyc;
        got++;
      end
      if (in_valid16 && in_ready16) sent++;
      @(posedge clk); #1;
    end
    in_valid16 = 1'b0; out_ready16 = 1'b1;
    checks++; if (got != 8) begin errors++; $display("[TB] FAIL stream_count: got %0d want 8", got); end
  endtask

  task automatic test_reset_flush();
    res_t e;
    int   lat;
    out_ready16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid16 = 1'b1; a16 = 16'h0100 + 16'(i); b16 = 16'h0022; c16 = 1'b0; sub16 = 1'b0;
      @(posedge clk); #1;
    end
    in_valid16 = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid16 !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid[%0d]: got %b want 0", i, out_valid16); end
      @(posedge clk); #1;
    end
    a16 = 16'h4321; b16 = 16'h1111; c16 = 1'b1; sub16 = 1'b1; in_valid16 = 1'b1;
    e = model(16, 64'h4321, 64'h1111, 1'b1, 1'b1);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 1;
    while (out_valid16 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != 4) begin errors++; $display("[TB] FAIL flush_latency: got %0d want 4", lat); end
    checks++;
    if ({s16, co16, v16, z16} !== {e.s[15:0], e.co, e.v, e.z}) begin
      errors++;
      $display("[TB] FAIL flush_result: got s=%h c=%b v=%b z=%b want s=%h c=%b v=%b z=%b",
               s16, co16, v16, z16, e.s[15:0], e.co, e.v, e.z);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int nbeats);
    res_t q16[$], q32[$], q8[$];
    res_t e;
    int   acc16 = 0, acc32 = 0, acc8 = 0, cyc = 0;
    bit   busy = 1'b1;
    while (busy && cyc < 60000) begin
      in_valid16  = (acc16 < nbeats) && ($urandom_range(3) != 0);
      a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom); sub16 = 1'($urandom);
      out_ready16 = ($urandom_range(3) != 0);
      in_valid_x  = ((acc32 < nbeats) || (acc8 < nbeats)) && ($urandom_range(3) != 0);
      a_x = $urandom; b_x = $urandom; c_x = 1'($urandom); sub_x = 1'($urandom);
      out_ready_x = ($urandom_range(4) != 0);
      #1;
      if (out_valid16 && out_ready16) begin
        checks++;
        if (q16.size() == 0) begin errors++; $display("[TB] FAIL random16_extra: got beat s=%h want none", s16); end
        else begin
          e = q16.pop_front();
          if ({s16, co16, v16, z16} !== {e.s[15:0], e.co, e.v, e.z}) begin
            errors++;
            $display("[TB] FAIL random16: got s=%h c=%b v=%b z=%b want s=%h c=%b v=%b z=%b",
                     s16, co16, v16, z16, e.s[15:0], e.co, e.v, e.z);
          end
        end
      end
      if (out_valid32 && out_ready_x) begin
        checks++;
        if (q32.size() == 0) begin errors++; $display("[TB] FAIL random32_extra: got beat s=%h want none", s32); end
        else begin
          e = q32.pop_front();
          if ({s32, co32, v32, z32} !== {e.s[31:0], e.co, e.v, e.z}) begin
            errors++;
            $display("[TB] FAIL random32: got s=%h c=%b v=%b z=%b want s=%h c=%b v=%b z=%b",
                     s32, co32, v32, z32, e.s[31:0], e.co, e.v, e.z);
          end
        end
      end
      if (out_valid8 && out_ready_x) begin
        checks++;
        if (q8.size() == 0) begin errors++; $display("[TB] FAIL random8_extra: got beat s=%h want none", s8); end
        else begin
          e = q8.pop_front();
          if ({s8, co8, v8, z8} !== {e.s[7:0], e.co, e.v, e.z}) begin
            errors++;
            $display("[TB] FAIL random8: got s=%h c=%b v=%b z=%b want s=%h c=%b v=%b z=%b",
                     s8, co8, v8, z8, e.s[7:0], e.co, e.v, e.z);
          end
        end
      end
      if (in_valid16 && in_ready16) begin q16.push_back(model(16, {48'b0, a16}, {48'b0, b16}, c16, sub16)); acc16++; end
      if (in_valid_x && in_ready32) begin q32.push_back(model(32, {32'b0, a_x}, {32'b0, b_x}, c_x, sub_x)); acc32++; end
      if (in_valid_x && in_ready8) begin q8.push_back(model(8, {32'b0, a_x}, {32'b0, b_x}, c_x, sub_x)); acc8++; end
      busy = (acc16 < nbeats) || (acc32 < nbeats) || (acc8 < nbeats) ||
             (q16.size() != 0) || (q32.size() != 0) || (q8.size() != 0);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid16 = 1'b0; in_valid_x = 1'b0;
    checks++; if (busy) begin errors++; $display("[TB] FAIL random_timeout: got %0d/%0d/%0d beats accepted want %0d each, all drained", acc16, acc32, acc8, nbeats); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_reset_flush();
    test_random(10000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
